// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;

  // ceil(width * log10(2)) in fixed point; enough digits to hold 2^width-1.
  function automatic int bcd_digits_for(input int width);
    longint num;
    num = longint'(width) * 64'sd30103 + 64'sd99999;
    return int'(num / 64'sd100000);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle between producers, the converter and display drivers.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  import bin2bcd_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W-1:0]              in_bin;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
  logic                          out_ovf;
  logic [DIGITS-1:0]             out_blank;

  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, out_ovf, out_blank
  );

  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, out_ovf, out_blank
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter, one input bit per clock.
// Leading-zero blanking is built only when BIN2BCD_SEQ_LZB_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic           clk,
  input logic           rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] corr;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ovf_next;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_bcd_r;
  logic             out_ovf_r;
  logic             last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A one leaving the top of the corrected accumulator means value >= 10^DIGITS.
  assign acc_next   = {corr[ACC_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_next   = ovf | corr[ACC_W-1];
  assign last_shift = (state == SHIFT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin_sr      <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_bcd_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_sr     <= bus.in_bin;
            acc        <= '0;
            ovf        <= 1'b0;
            cnt        <= CNT_W'(BIN_W - 1);
            in_ready_r <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= bin_sr << 1;
          ovf    <= ovf_next;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            out_bcd_r   <= acc_next;
            out_ovf_r   <= ovf_next;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bcd   = out_bcd_r;
  assign bus.out_ovf   = out_ovf_r;

`ifdef BIN2BCD_SEQ_LZB_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] out_blank_r;
  logic [DIGITS-1:0] blank_next;
  logic              higher_zero;

  // Blank a digit only while every more significant digit is also zero.
  always_comb begin
    blank_next  = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero   = higher_zero & (acc_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_next[i] = higher_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_blank_r <= BLANK_RST;
    end else if (last_shift) begin
      out_blank_r <= blank_next;
    end
  end

  assign bus.out_blank = out_blank_r;
`else
  assign bus.out_blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq in 8/3, 8/2 and 16/5 configurations.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SEQ_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) a ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) c ();

  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(a));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(b));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_c (.clk(clk), .rst(rst), .bus(c));

  // One handshake per call; lat counts edges from the accepting edge to out_valid.
  task automatic run_a(input logic [7:0] v, output logic [11:0] bcd, output logic ovf,
                       output logic [2:0] blank, output int lat);
    @(negedge clk); a.in_bin = v; a.in_valid = 1'b1; a.out_ready = 1'b0;
    @(posedge clk); #1; a.in_valid = 1'b0; lat = 1;
    while (a.out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    bcd = a.out_bcd; ovf = a.out_ovf; blank = a.out_blank;
    @(negedge clk); a.out_ready = 1'b1;
    @(posedge clk); #1; a.out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [7:0] v, output logic [7:0] bcd, output logic ovf,
                       output logic [1:0] blank, output int lat);
    @(negedge clk); b.in_bin = v; b.in_valid = 1'b1; b.out_ready = 1'b0;
    @(posedge clk); #1; b.in_valid = 1'b0; lat = 1;
    while (b.out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    bcd = b.out_bcd; ovf = b.out_ovf; blank = b.out_blank;
    @(negedge clk); b.out_ready = 1'b1;
    @(posedge clk); #1; b.out_ready = 1'b0;
  endtask

  task automatic run_c(input logic [15:0] v, output logic [19:0] bcd, output logic ovf,
                       output logic [4:0] blank, output int lat);
    @(negedge clk); c.in_bin = v; c.in_valid = 1'b1; c.out_ready = 1'b0;
    @(posedge clk); #1; c.in_valid = 1'b0; lat = 1;
    while (c.out_valid !== 1'b1 && lat < 80) begin @(posedge clk); #1; lat++; end
    bcd = c.out_bcd; ovf = c.out_ovf; blank = c.out_blank;
    @(negedge clk); c.out_ready = 1'b1;
    @(posedge clk); #1; c.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b want 1", a.in_ready); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", a.out_valid); end
    checks++; if (a.out_bcd !== 12'h000) begin errors++; $display("[TB] FAIL rst_out_bcd got %h want 000", a.out_bcd); end
    checks++; if (a.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_ovf got %b want 0", a.out_ovf); end
    checks++; if (a.out_blank !== (LZB ? 3'b110 : 3'b000)) begin errors++; $display("[TB] FAIL rst_blank_a got %b want %b", a.out_blank, LZB ? 3'b110 : 3'b000); end
    checks++; if (c.out_blank !== (LZB ? 5'b11110 : 5'b00000)) begin errors++; $display("[TB] FAIL rst_blank_c got %b want %b", c.out_blank, LZB ? 5'b11110 : 5'b00000); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_three_digits();
    logic [11:0] bcd; logic ovf; logic [2:0] blank; int lat;
    run_a(8'd255, bcd, ovf, blank, lat);
    checks++; if (bcd !== 12'h255) begin errors++; $display("[TB] FAIL d3_255_bcd got %h want 255", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL d3_255_ovf got %b want 0", ovf); end
    checks++; if (blank !== 3'b000) begin errors++; $display("[TB] FAIL d3_255_blank got %b want 000", blank); end
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL d3_latency got %0d want 9", lat); end
    run_a(8'd0, bcd, ovf, blank, lat);
    checks++; if (bcd !== 12'h000) begin errors++; $display("[TB] FAIL d3_0_bcd got %h want 000", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL d3_0_ovf got %b want 0", ovf); end
    checks++; if (blank !== (LZB ? 3'b110 : 3'b000)) begin errors++; $display("[TB] FAIL d3_0_blank got %b want %b", blank, LZB ? 3'b110 : 3'b000); end
  endtask

  task automatic test_overflow();
    logic [7:0] bcd; logic ovf; logic [1:0] blank; int lat;
    run_b(8'd255, bcd, ovf, blank, lat);
    checks++; if (bcd !== 8'h55) begin errors++; $display("[TB] FAIL d2_255_bcd got %h want 55", bcd); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL d2_255_ovf got %b want 1", ovf); end
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL d2_latency got %0d want 9", lat); end
    run_b(8'd99, bcd, ovf, blank, lat);
    checks++; if (bcd !== 8'h99) begin errors++; $display("[TB] FAIL d2_99_bcd got %h want 99", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL d2_99_ovf got %b want 0", ovf); end
    run_b(8'd100, bcd, ovf, blank, lat);
    checks++; if (bcd !== 8'h00) begin errors++; $display("[TB] FAIL d2_100_bcd got %h want 00", bcd); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL d2_100_ovf got %b want 1", ovf); end
    checks++; if (blank !== (LZB ? 2'b10 : 2'b00)) begin errors++; $display("[TB] FAIL d2_100_blank got %b want %b", blank, LZB ? 2'b10 : 2'b00); end
  endtask

  task automatic test_wide();
    logic [19:0] bcd; logic ovf; logic [4:0] blank; int lat;
    run_c(16'd65535, bcd, ovf, blank, lat);
    checks++; if (bcd !== 20'h65535) begin errors++; $display("[TB] FAIL w_65535_bcd got %h want 65535", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL w_65535_ovf got %b want 0", ovf); end
    checks++; if (lat != 17) begin errors++; $display("[TB] FAIL w_latency got %0d want 17", lat); end
    run_c(16'd40, bcd, ovf, blank, lat);
    checks++; if (bcd !== 20'h00040) begin errors++; $display("[TB] FAIL w_40_bcd got %h want 00040", bcd); end
    checks++; if (blank !== (LZB ? 5'b11100 : 5'b00000)) begin errors++; $display("[TB] FAIL w_40_blank got %b want %b", blank, LZB ? 5'b11100 : 5'b00000); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk); a.in_bin = 8'd123; a.in_valid = 1'b1; a.out_ready = 1'b0;
    @(posedge clk); #1; a.in_valid = 1'b0; n = 1;
    while (a.out_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    checks++; if (n != 9) begin errors++; $display("[TB] FAIL bp_latency got %0d want 9", n); end
    // A competing request while DONE stalls must not disturb the held result.
    @(negedge clk); a.in_bin = 8'd7; a.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (a.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cyc %0d got %b want 1", i, a.out_valid); end
      checks++; if (a.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc %0d got %b want 0", i, a.in_ready); end
      checks++; if (a.out_bcd !== 12'h123) begin errors++; $display("[TB] FAIL bp_bcd cyc %0d got %h want 123", i, a.out_bcd); end
    end
    @(negedge clk); a.in_valid = 1'b0; a.out_ready = 1'b1;
    @(posedge clk); #1; a.out_ready = 1'b0;
    checks++; if (a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready got %b want 1", a.in_ready); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b want 0", a.out_valid); end
    checks++; if (a.out_bcd !== 12'h123) begin errors++; $display("[TB] FAIL bp_hold_bcd got %h want 123", a.out_bcd); end
  endtask

  task automatic test_reset_mid_shift();
    logic [11:0] bcd; logic ovf; logic [2:0] blank; int lat;
    @(negedge clk); a.in_bin = 8'd200; a.in_valid = 1'b1;
    @(posedge clk); #1; a.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a.out_bcd !== 12'h123) begin errors++; $display("[TB] FAIL shift_hold_bcd got %h want 123", a.out_bcd); end
    checks++; if (a.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL shift_in_ready got %b want 0", a.in_ready); end
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", a.out_valid); end
    checks++; if (a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_in_ready got %b want 1", a.in_ready); end
    checks++; if (a.out_bcd !== 12'h000) begin errors++; $display("[TB] FAIL mid_rst_bcd got %h want 000", a.out_bcd); end
    checks++; if (a.out_blank !== (LZB ? 3'b110 : 3'b000)) begin errors++; $display("[TB] FAIL mid_rst_blank got %b want %b", a.out_blank, LZB ? 3'b110 : 3'b000); end
    @(negedge clk); rst = 1'b0;
    run_a(8'd42, bcd, ovf, blank, lat);
    checks++; if (bcd !== 12'h042) begin errors++; $display("[TB] FAIL after_rst_42_bcd got %h want 042", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_42_ovf got %b want 0", ovf); end
    checks++; if (blank !== (LZB ? 3'b100 : 3'b000)) begin errors++; $display("[TB] FAIL after_rst_42_blank got %b want %b", blank, LZB ? 3'b100 : 3'b000); end
    checks++; if (lat != 9) begin errors++; $display("[TB] FAIL after_rst_latency got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic prev = 1'b0;
    logic [11:0] bcd2 = 12'hfff;
    @(negedge clk); a.in_bin = 8'd37; a.in_valid = 1'b1; a.out_ready = 1'b1;
    for (int e = 1; e <= 40 && second < 0; e++) begin
      @(posedge clk); #1;
      if (a.out_valid === 1'b1 && !prev) begin
        if (first < 0) first = e;
        else begin second = e; bcd2 = a.out_bcd; end
      end
      prev = a.out_valid;
    end
    checks++; if (first != 9) begin errors++; $display("[TB] FAIL b2b_first got %0d want 9", first); end
    checks++; if (second - first != 10) begin errors++; $display("[TB] FAIL b2b_period got %0d want 10", second - first); end
    checks++; if (bcd2 !== 12'h037) begin errors++; $display("[TB] FAIL b2b_bcd got %h want 037", bcd2); end
    @(negedge clk); a.in_valid = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk); a.out_ready = 1'b0;
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_bin = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_bin = '0; b.out_ready = 1'b0;
    c.in_valid = 1'b0; c.in_bin = '0; c.out_ready = 1'b0;
    test_reset();
    test_three_digits();
    test_overflow();
    test_wide();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
